// File: rtl/gmii_rx_capture_pkg.sv
// Shared types and constants for the GMII receive capture block and its logger.
package gmii_rx_capture_pkg;

  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         MAX_BYTES_DEF = 504;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_CAPTURE,
    ST_DISCARD,
    ST_FINISH
  } rx_state_e;

  // Metadata word layout, MSB first: [63:32] ts, [31:16] len, [15] err,
  // [14] trunc, [13] drop nonzero, [12:8] zero, [7:0] seq.
  typedef struct packed {
    logic [31:0] ts;
    logic [15:0] len;
    logic        err;
    logic        trunc;
    logic        drop_nz;
    logic [4:0]  rsvd;
    logic [7:0]  seq;
  } meta_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gmii_rx_capture_fifo.sv
// Synchronous FIFO with registered read data and an optional commit pointer.
// With USE_COMMIT set, written entries become visible to the reader only
// when commit is pulsed; free space always counts uncommitted writes.
module gmii_sync_fifo #(
  parameter int W          = 8,
  parameter int AW         = 4,
  parameter bit USE_COMMIT = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          commit,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   free
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, pub_ptr_q, pub_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]  vis_ptr;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic         empty;

  assign vis_ptr = USE_COMMIT ? pub_ptr_q : wr_ptr_q;
  assign empty   = (rd_ptr_q == vis_ptr);
  assign free    = DEPTH_V - (wr_ptr_q - rd_ptr_q);
  assign rd_data = rd_data_q;

  // Pointer advance and read-register load; a pop on empty is ignored.
  always_comb begin
    wr_ptr_d  = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    pub_ptr_d = commit ? wr_ptr_d : pub_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (rd_en && !empty) begin
      rd_ptr_d  = rd_ptr_q + ONE;
      rd_data_d = mem[rd_ptr_q[AW-1:0]];
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Pointer and read-data registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      pub_ptr_q <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      pub_ptr_q <= pub_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/gmii_rx_capture.sv
// GMII receive capture: strips preamble/SFD, stores frame bytes with a stop
// marker in a byte buffer and one metadata word per frame in a meta FIFO.
module gmii_rx_capture
  import gmii_rx_capture_pkg::*;
#(
  parameter int DATA_AW   = 11,
  parameter int META_AW   = 4,
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        available,
  output logic [63:0] meta,
  input  logic        meta_en,
  output logic [7:0]  data,
  output logic        data_stop,
  input  logic        data_en,
  output logic [15:0] drop_count
);

  localparam logic [DATA_AW:0] MAX_FREE   = (DATA_AW+1)'(MAX_BYTES);
  localparam logic [15:0]      LAST_IDX   = 16'(MAX_BYTES - 1);
  localparam logic [META_AW:0] META_DEPTH = {1'b1, {META_AW{1'b0}}};

  rx_state_e   state_q, state_d;
  logic [31:0] ts_q, ts_d, sfd_ts_q, sfd_ts_d;
  logic [15:0] len_q, len_d, drop_q, drop_d;
  logic        err_q, err_d, trunc_q, trunc_d, captured_q, captured_d;
  logic [7:0]  held_q, held_d, seq_q, seq_d;
  logic        held_vld_q, held_vld_d;

  logic             bw_en, finish;
  logic [8:0]       bw_data, byte_rd;
  logic [DATA_AW:0] byte_free;
  logic [META_AW:0] meta_free;
  meta_t            meta_w;

  // Frame FSM; buffer space for a whole frame is reserved at the SFD, so a
  // captured frame never needs rewinding. The last received byte is held one
  // cycle so it can be written with its stop bit once dv falls.
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + 32'd1;
    sfd_ts_d   = sfd_ts_q;
    len_d      = len_q;
    err_d      = err_q;
    trunc_d    = trunc_q;
    captured_d = captured_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    bw_en      = 1'b0;
    bw_data    = {1'b0, held_q};
    finish     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (gmii_rx_dv) state_d = ST_PREAMBLE;
      ST_PREAMBLE: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
        else if (gmii_rxd == SFD_BYTE) begin
          sfd_ts_d   = ts_q;
          len_d      = '0;
          err_d      = 1'b0;
          trunc_d    = 1'b0;
          held_vld_d = 1'b0;
          if (byte_free < MAX_FREE || meta_free == '0) begin
            state_d    = ST_DISCARD;
            captured_d = 1'b0;
            drop_d     = sat_inc16(drop_q);
          end else begin
            state_d    = ST_CAPTURE;
            captured_d = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (gmii_rx_dv) begin
          len_d      = sat_inc16(len_q);
          err_d      = err_q | gmii_rx_er;
          bw_en      = held_vld_q;
          held_d     = gmii_rxd;
          held_vld_d = 1'b1;
          // This byte is the last one that fits; it is flushed with stop=1
          // on the first DISCARD cycle.
          if (len_q == LAST_IDX) begin
            trunc_d = 1'b1;
            state_d = ST_DISCARD;
          end
        end else if (held_vld_q) begin
          bw_en      = 1'b1;
          bw_data    = {1'b1, held_q};
          held_vld_d = 1'b0;
          state_d    = ST_FINISH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (held_vld_q) begin
          bw_en      = 1'b1;
          bw_data    = {1'b1, held_q};
          held_vld_d = 1'b0;
        end
        if (gmii_rx_dv) len_d = sat_inc16(len_q);
        else state_d = captured_q ? ST_FINISH : ST_IDLE;
      end
      ST_FINISH: begin
        finish  = 1'b1;
        seq_d   = seq_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Metadata word assembled from the per-frame registers.
  always_comb begin
    meta_w         = '0;
    meta_w.ts      = sfd_ts_q;
    meta_w.len     = len_q;
    meta_w.err     = err_q;
    meta_w.trunc   = trunc_q;
    meta_w.drop_nz = |drop_q;
    meta_w.seq     = seq_q;
  end

  // State and per-frame registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      sfd_ts_q   <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      trunc_q    <= 1'b0;
      captured_q <= 1'b0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      seq_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      sfd_ts_q   <= sfd_ts_d;
      len_q      <= len_d;
      err_q      <= err_d;
      trunc_q    <= trunc_d;
      captured_q <= captured_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
    end
  end

  gmii_sync_fifo #(.W(9), .AW(DATA_AW), .USE_COMMIT(1'b1)) u_byte_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (bw_en),
    .wr_data (bw_data),
    .commit  (finish),
    .rd_en   (data_en),
    .rd_data (byte_rd),
    .free    (byte_free)
  );

  gmii_sync_fifo #(.W(64), .AW(META_AW), .USE_COMMIT(1'b0)) u_meta_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (finish),
    .wr_data (meta_w),
    .commit  (1'b0),
    .rd_en   (meta_en),
    .rd_data (meta),
    .free    (meta_free)
  );

  assign available  = (meta_free != META_DEPTH);
  assign data       = byte_rd[7:0];
  assign data_stop  = byte_rd[8];
  assign drop_count = drop_q;

endmodule

// File: tb/tb_gmii_rx_capture.sv
// Bench for gmii_rx_capture: frame-level reference model with queues.
module tb_gmii_rx_capture;

  logic        clock = 1'b0, reset_n = 1'b1;
  logic        gmii_rx_dv = 1'b0, gmii_rx_er = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        available, data_stop;
  logic [63:0] meta;
  logic        meta_en = 1'b0, data_en = 1'b0;
  logic [7:0]  data;
  logic [15:0] drop_count;

  always #5 clock = ~clock;

  gmii_rx_capture dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .gmii_rxd   (gmii_rxd),
    .available  (available),
    .meta       (meta),
    .meta_en    (meta_en),
    .data       (data),
    .data_stop  (data_stop),
    .data_en    (data_en),
    .drop_count (drop_count)
  );

  int n_chk = 0, n_fail = 0;

  // Model state
  logic [63:0] mq[$];
  logic [8:0]  bq[$];
  logic [63:0] exp_meta = '0;
  logic [8:0]  exp_byte = '0;
  logic [15:0] exp_drop = '0;
  logic [7:0]  exp_seq  = '0;
  int          buffered = 0;
  logic [31:0] cyc;
  bit          chk_on = 1'b0;

  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= '0; else cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n && chk_on) begin
      check("available", 64'(available), 64'(mq.size() != 0));
      check("meta", meta, exp_meta);
      check("data", 64'({data_stop, data}), 64'(exp_byte));
      check("drop_count", 64'(drop_count), 64'(exp_drop));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input bit dv, input bit er, input logic [7:0] d);
    gmii_rx_dv = dv; gmii_rx_er = er; gmii_rxd = d;
    tick();
  endtask

  task automatic send_frame(input int pre, input int len, input int er_pos, input bit rnd);
    logic [7:0]  fb[$];
    bit          acc;
    logic [31:0] ts;
    int          ns;
    for (int i = 0; i < len; i++) fb.push_back(rnd ? 8'($urandom) : 8'(i));
    for (int i = 0; i < pre; i++) drv(1'b1, 1'b0, 8'h55);
    acc = ((2048 - buffered) >= 504) && (mq.size() < 16);
    ts  = cyc;
    drv(1'b1, 1'b0, 8'hD5);
    if (!acc && exp_drop != 16'hFFFF) exp_drop++;
    for (int i = 0; i < len; i++) drv(1'b1, i == er_pos, fb[i]);
    drv(1'b0, 1'b0, 8'h00);
    drv(1'b0, 1'b0, 8'h00);
    if (acc && len > 0) begin
      ns = (len < 504) ? len : 504;
      for (int i = 0; i < ns; i++) bq.push_back({i == ns - 1, fb[i]});
      buffered += ns;
      mq.push_back({ts, 16'(len), (er_pos >= 0 && er_pos < ns), len >= 504,
                    exp_drop != 16'd0, 5'b0, exp_seq});
      exp_seq++;
    end
    drv(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pop_meta();
    meta_en = 1'b1; tick(); meta_en = 1'b0;
    if (mq.size() != 0) exp_meta = mq.pop_front();
  endtask

  task automatic pop_data();
    data_en = 1'b1; tick(); data_en = 1'b0;
    if (bq.size() != 0) begin exp_byte = bq.pop_front(); buffered--; end
  endtask

  task automatic drain_all();
    while (mq.size() != 0) pop_meta();
    while (bq.size() != 0) pop_data();
    pop_data();
    pop_meta();
  endtask

  task automatic model_reset();
    mq.delete(); bq.delete();
    exp_meta = '0; exp_byte = '0; exp_drop = '0; exp_seq = '0; buffered = 0;
  endtask

  initial begin
    int len, er_pos;
    #2 reset_n = 1'b0;
    #20;
    check("rst_available", 64'(available), 64'd0);
    check("rst_meta", meta, 64'd0);
    check("rst_data", 64'({data_stop, data}), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_on  = 1'b1;
    tick();

    // 60-byte frame with incrementing data
    send_frame(7, 60, -1, 1'b0);
    check("t1_model_bytes", 64'(bq.size()), 64'd60);
    pop_meta();
    check("t1_meta_low", 64'(meta[31:0]), 64'h003C_0000);
    drain_all();
    check("t1_last_byte", 64'({data_stop, data}), 64'h13B);

    // 600-byte frame gets truncated to 504 stored bytes
    send_frame(7, 600, -1, 1'b0);
    check("t2_model_bytes", 64'(bq.size()), 64'd504);
    pop_meta();
    check("t2_meta_len", 64'(meta[31:16]), 64'd600);
    check("t2_meta_flags", 64'(meta[15:13]), 64'b010);
    check("t2_meta_seq", 64'(meta[7:0]), 64'd1);
    drain_all();
    check("t2_last_byte", 64'({data_stop, data}), 64'h1F7);

    // rx_er on byte 10 of a 64-byte frame
    send_frame(7, 64, 10, 1'b0);
    check("t3_model_bytes", 64'(bq.size()), 64'd64);
    pop_meta();
    check("t3_meta", 64'(meta[31:0]), 64'h0040_8002);
    drain_all();

    // aborted preamble and an empty frame leave no trace
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 8'h55);
    drv(1'b0, 1'b0, 8'h00);
    drv(1'b0, 1'b0, 8'h00);
    send_frame(7, 0, -1, 1'b0);
    repeat (3) tick();
    check("t4_available", 64'(available), 64'd0);
    check("t4_drop", 64'(drop_count), 64'd0);

    // fill the byte buffer until a frame is dropped
    for (int f = 0; f < 4; f++) send_frame(7, 504, -1, 1'b1);
    send_frame(7, 100, -1, 1'b1);
    check("t5_drop", 64'(drop_count), 64'd1);
    check("t5_model_meta", 64'(mq.size()), 64'd4);
    drain_all();
    send_frame(7, 60, -1, 1'b1);
    pop_meta();
    check("t5_meta_flags", 64'(meta[15:13]), 64'b001);
    drain_all();

    // randomized frames with partial draining
    for (int f = 0; f < 40; f++) begin
      len    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(400, 700))
                                           : int'($urandom_range(0, 120));
      er_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len + 5)) : -1;
      send_frame(int'($urandom_range(1, 7)), len, er_pos, 1'b1);
      if (f % 10 == 9) drain_all();
      else begin
        repeat ($urandom_range(0, 2)) pop_meta();
        repeat ($urandom_range(0, 150)) pop_data();
      end
    end

    // reset in the middle of a frame
    for (int i = 0; i < 7; i++) drv(1'b1, 1'b0, 8'h55);
    drv(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drv(1'b1, 1'b0, 8'(i + 7));
    reset_n = 1'b0;
    gmii_rx_dv = 1'b0;
    #1;
    check("t6_rst_available", 64'(available), 64'd0);
    check("t6_rst_meta", meta, 64'd0);
    check("t6_rst_data", 64'({data_stop, data}), 64'd0);
    check("t6_rst_drop", 64'(drop_count), 64'd0);
    model_reset();
    @(negedge clock); #2;
    reset_n = 1'b1;
    tick();
    send_frame(3, 30, -1, 1'b1);
    pop_meta();
    check("t6_meta", 64'(meta[31:0]), 64'h001E_0000);
    drain_all();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
